button_repeat: RTL and testbench

//  Per-button press / auto-repeat / long-press generator, clocked on clk_pix.

---
 rtl/button_repeat_if.sv | 25 ++
 rtl/button_repeat.sv | 155 +++++++++++++++
 tb/tb_button_repeat.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/button_repeat_if.sv
// Button bus between the debounced button source and button_repeat.
// master: drives debounced button levels, observes the events.
// slave : button_repeat itself.
// The release pulse is carried on "rel" because "release" is a reserved word.
interface button_repeat_if #(
   parameter int N = 5
);
   logic [N-1:0]   btn;
   logic [N-1:0]   press;
   logic [N-1:0]   rpt;
   logic [N-1:0]   fire;
   logic [N-1:0]   held;
   logic [N-1:0]   rel;
   logic [8*N-1:0] rpt_cnt;

   modport master (
      output btn,
      input  press, rpt, fire, held, rel, rpt_cnt
   );

   modport slave (
      input  btn,
      output press, rpt, fire, held, rel, rpt_cnt
   );
endinterface

// File: rtl/button_repeat.sv
// button_repeat: per-button press / auto-repeat / long-press event generator.
// Each channel runs LOCK -> IDLE -> PRESS -> REPEAT with one shared-width
// counter; all event outputs are registered (1-edge latency) except fire.
// Optional feature: define BUTTON_REPEAT_COUNT_EN to build a saturating
// 8-bit per-channel repeat counter on rpt_cnt; otherwise rpt_cnt is 0.
module button_repeat #(
   parameter int N             = 5,
   parameter int HOLD_CYCLES   = 20_000_000,
   parameter int REPEAT_CYCLES = 4_000_000
) (
   input  logic          clk,
   input  logic          reset,
   button_repeat_if.slave bus
);
   localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CW-1:0] HOLD_TC   = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      LOCK   = 2'd0,
      IDLE   = 2'd1,
      PRESS  = 2'd2,
      REPEAT = 2'd3
   } state_t;

   logic [N-1:0]   press_vec;
   logic [N-1:0]   rpt_vec;
   logic [N-1:0]   held_vec;
   logic [N-1:0]   rel_vec;
   logic [8*N-1:0] cnt_vec;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_ch
         state_t        state_q, state_d;
         logic [CW-1:0] cnt_q, cnt_d;
         logic          press_q, press_d;
         logic          rpt_q, rpt_d;
         logic          held_q, held_d;
         logic          rel_q, rel_d;
         logic          btn_in;

         assign btn_in = bus.btn[gi];

         // Channel state, timer and registered event pulses.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               state_q <= LOCK;
               cnt_q   <= '0;
               press_q <= 1'b0;
               rpt_q   <= 1'b0;
               held_q  <= 1'b0;
               rel_q   <= 1'b0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
               press_q <= press_d;
               rpt_q   <= rpt_d;
               held_q  <= held_d;
               rel_q   <= rel_d;
            end
         end

         // Next state and events; a low btn is checked first so release beats terminal count.
         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rpt_d   = 1'b0;
            rel_d   = 1'b0;
            held_d  = held_q;
            case (state_q)
               LOCK: begin
                  if (!btn_in) state_d = IDLE;
               end
               IDLE: begin
                  if (btn_in) begin
                     state_d = PRESS;
                     cnt_d   = '0;
                     press_d = 1'b1;
                  end
               end
               PRESS: begin
                  if (!btn_in) begin
                     state_d = IDLE;
                     rel_d   = 1'b1;
                  end else if (cnt_q == HOLD_TC) begin
                     state_d = REPEAT;
                     cnt_d   = '0;
                     rpt_d   = 1'b1;
                     held_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
               REPEAT: begin
                  if (!btn_in) begin
                     state_d = IDLE;
                     rel_d   = 1'b1;
                     held_d  = 1'b0;
                  end else if (cnt_q == REPEAT_TC) begin
                     cnt_d = '0;
                     rpt_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
               default: begin
                  state_d = LOCK;
                  held_d  = 1'b0;
               end
            endcase
         end

         assign press_vec[gi] = press_q;
         assign rpt_vec[gi]   = rpt_q;
         assign held_vec[gi]  = held_q;
         assign rel_vec[gi]   = rel_q;

`ifdef BUTTON_REPEAT_COUNT_EN
         logic [7:0] rc_q, rc_d;

         // Repeat count: cleared by a new press, saturating increment alongside rpt.
         always_comb begin
            rc_d = rc_q;
            if (press_d) begin
               rc_d = 8'd0;
            end else if (rpt_d && (rc_q != 8'hFF)) begin
               rc_d = rc_q + 8'd1;
            end
         end

         // Repeat count register, cleared by reset.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) rc_q <= 8'd0;
            else        rc_q <= rc_d;
         end

         assign cnt_vec[8*gi +: 8] = rc_q;
`endif
      end
   endgenerate

`ifndef BUTTON_REPEAT_COUNT_EN
   assign cnt_vec = '0;
`endif

   assign bus.press   = press_vec;
   assign bus.rpt     = rpt_vec;
   assign bus.held    = held_vec;
   assign bus.rel     = rel_vec;
   assign bus.rpt_cnt = cnt_vec;
   assign bus.fire    = press_vec | rpt_vec;
endmodule

// File: tb/tb_button_repeat.sv
// Testbench for button_repeat (N=2, HOLD_CYCLES=8, REPEAT_CYCLES=4).
// Driver applies inputs on the falling edge and pushes the expected
// post-edge outputs from a hold-time reference model into a queue;
// a monitor pops and compares after every rising edge.
module tb_button_repeat;
   localparam int N = 2;
   localparam int H = 8;
   localparam int R = 4;

   typedef struct packed {
      logic [N-1:0]   press;
      logic [N-1:0]   rpt;
      logic [N-1:0]   held;
      logic [N-1:0]   rel;
      logic [8*N-1:0] cnt;
   } exp_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   exp_t exp_q[$];

   // reference model state: per channel
   bit   armed[N];
   bit   active[N];
   int   press_edge[N];
   int   rcnt[N];
   int   edge_no;

   button_repeat_if #(.N(N)) bus ();

   button_repeat #(
      .N(N),
      .HOLD_CYCLES(H),
      .REPEAT_CYCLES(R)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: events follow from how long the button has been held since its press.
   task automatic model_step(input logic [N-1:0] b, input logic r);
      exp_t x;
      int   t;
      x = '0;
      edge_no++;
      for (int ch = 0; ch < N; ch++) begin
         if (!r) begin
            armed[ch]  = 1'b0;
            active[ch] = 1'b0;
            rcnt[ch]   = 0;
         end else if (!active[ch]) begin
            if (armed[ch] && b[ch]) begin
               x.press[ch]    = 1'b1;
               active[ch]     = 1'b1;
               press_edge[ch] = edge_no;
               rcnt[ch]       = 0;
            end
            if (!b[ch]) armed[ch] = 1'b1;
         end else if (!b[ch]) begin
            x.rel[ch]  = 1'b1;
            active[ch] = 1'b0;
            armed[ch]  = 1'b1;
         end else begin
            t = edge_no - press_edge[ch];
            if (t >= H && ((t - H) % R) == 0) begin
               x.rpt[ch] = 1'b1;
               if (rcnt[ch] < 255) rcnt[ch]++;
            end
            x.held[ch] = (t >= H);
         end
`ifdef BUTTON_REPEAT_COUNT_EN
         x.cnt[8*ch +: 8] = rcnt[ch][7:0];
`else
         x.cnt[8*ch +: 8] = 8'd0;
`endif
      end
      exp_q.push_back(x);
   endtask

   // One cycle of stimulus; an asserting reset is checked to clear outputs at once.
   task automatic cyc(input logic [N-1:0] b, input logic r);
      logic prev_r;
      @(negedge clk);
      bus.btn = b;
      prev_r  = reset;
      reset   = r;
      if (prev_r && !r) begin
         #1;
         checks++;
         if ({bus.press, bus.rpt, bus.fire, bus.held, bus.rel, bus.rpt_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset_clear t=%0t got press=%b rpt=%b fire=%b held=%b rel=%b cnt=%h want all 0",
                     $time, bus.press, bus.rpt, bus.fire, bus.held, bus.rel, bus.rpt_cnt);
         end
      end
      model_step(b, r);
   endtask

   task automatic hold(input logic [N-1:0] b, input logic r, input int n);
      for (int i = 0; i < n; i++) cyc(b, r);
   endtask

   // Monitor: compare every presented output cycle against the next expectation.
   initial begin
      exp_t x;
      logic [N-1:0] fire_exp;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            fire_exp = x.press | x.rpt;
            checks++;
            if (bus.press !== x.press || bus.rpt !== x.rpt || bus.fire !== fire_exp ||
                bus.held !== x.held || bus.rel !== x.rel || bus.rpt_cnt !== x.cnt) begin
               errors++;
               $display("FAIL outputs t=%0t got p=%b r=%b f=%b h=%b rel=%b c=%h want p=%b r=%b f=%b h=%b rel=%b c=%h",
                        $time, bus.press, bus.rpt, bus.fire, bus.held, bus.rel, bus.rpt_cnt,
                        x.press, x.rpt, fire_exp, x.held, x.rel, x.cnt);
            end
            $display("cycle t=%0t btn=%b p=%b r=%b h=%b rel=%b c=%h", $time, bus.btn,
                     bus.press, bus.rpt, bus.held, bus.rel, bus.rpt_cnt);
         end
      end
   end

   // Stimulus: directed scenarios, then randomized traffic.
   initial begin
      errors  = 0;
      checks  = 0;
      edge_no = 0;
      for (int ch = 0; ch < N; ch++) begin
         armed[ch] = 1'b0; active[ch] = 1'b0; press_edge[ch] = 0; rcnt[ch] = 0;
      end
      reset   = 1'b0;
      bus.btn = '0;
      #1;
      checks++;
      if ({bus.press, bus.rpt, bus.fire, bus.held, bus.rel, bus.rpt_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_state got press=%b rpt=%b held=%b rel=%b cnt=%h want all 0",
                  bus.press, bus.rpt, bus.held, bus.rel, bus.rpt_cnt);
      end
      hold(2'b00, 1'b0, 3);
      hold(2'b00, 1'b1, 10);
      // short 3-cycle press: press then release, no rpt
      hold(2'b01, 1'b1, 3);
      hold(2'b00, 1'b1, 4);
      // 1-cycle press
      hold(2'b01, 1'b1, 1);
      hold(2'b00, 1'b1, 3);
      // 20-cycle hold: repeats at 8,12,16, release at 20
      hold(2'b01, 1'b1, 20);
      hold(2'b00, 1'b1, 3);
      // button 1 held through reset: locked until seen low
      hold(2'b10, 1'b0, 3);
      hold(2'b10, 1'b1, 30);
      hold(2'b00, 1'b1, 1);
      hold(2'b10, 1'b1, 3);
      hold(2'b00, 1'b1, 2);
      // two buttons 3 cycles apart
      hold(2'b01, 1'b1, 3);
      hold(2'b11, 1'b1, 30);
      hold(2'b00, 1'b1, 2);
      // reset pulse mid-hold
      hold(2'b01, 1'b1, 10);
      hold(2'b01, 1'b0, 1);
      hold(2'b01, 1'b1, 5);
      hold(2'b00, 1'b1, 1);
      hold(2'b01, 1'b1, 2);
      hold(2'b00, 1'b1, 2);
`ifdef BUTTON_REPEAT_COUNT_EN
      // long hold to saturate the repeat count, then a fresh press clears it
      hold(2'b01, 1'b1, H + R * 300);
      hold(2'b00, 1'b1, 3);
      hold(2'b01, 1'b1, 2);
      hold(2'b00, 1'b1, 2);
`endif
      // randomized traffic
      begin
         logic [N-1:0] b;
         b = '0;
         for (int i = 0; i < 2500; i++) begin
            for (int ch = 0; ch < N; ch++) begin
               if ($urandom_range(15) == 0) b[ch] = ~b[ch];
            end
            if ($urandom_range(299) == 0) hold(b, 1'b0, 1 + $urandom_range(1));
            else cyc(b, 1'b1);
         end
      end
      hold(2'b00, 1'b1, 2);
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
